// File: rtl/bloom_pkg.sv
// Shared types for the bloom filter request scheduler.
//   DATA_W / TAG_W : key and requester-tag widths used by every struct below
//   qry_req_t      : buffered query {tag, data}
//   rsp_t          : response FIFO entry {tag, data, hit}
//   sched_state_e  : scheduler FSM states
package bloom_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } qry_req_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              hit;
    } rsp_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/bloom_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
//   clk, rst         : clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data   : write strobe and entry; ignored while full
//   rd_en            : pop the head entry; ignored while empty
//   rd_data          : current head entry (valid when !empty)
//   full, empty      : occupancy flags
// A write while full is dropped even if the same cycle pops, so a full FIFO
// never accepts in the cycle it is read.
module bloom_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  T     wr_data,
    input  logic rd_en,
    output T     rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty after wrap-around.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];

    logic do_wr;
    logic do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bloom_req_sched.sv
// Request scheduler in front of bloom_filter.
// Buffers inserts and tagged queries, issues at most one bloom_filter op per
// cycle (inserts first), lines up bf_query_result with the query that caused
// it and returns in-order tagged responses with backpressure.
//   clk, rst                         : clock, synchronous active-high reset
//   ins_valid/ins_ready/ins_data     : insert request port
//   qry_valid/qry_ready/qry_data/qry_tag : query request port
//   rsp_valid/rsp_ready/rsp_hit/rsp_tag/rsp_data : response port
//   bf_insert_valid/bf_insert_data   : insert strobe to bloom_filter
//   bf_query_valid/bf_query_data     : query strobe to bloom_filter
//   bf_query_result                  : hit bit, valid QRY_LAT cycles after strobe
// Key and tag widths come from bloom_pkg so the struct types stay consistent.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | bit array being cleared; no requests accepted, no strobes
// ST_RUN  | normal operation; left only through rst
module bloom_req_sched
    import bloom_pkg::*;
#(
    parameter int QDEPTH   = 4,
    parameter int QRY_LAT  = 1,
    parameter int INIT_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [DATA_W-1:0] ins_data,
    input  logic              qry_valid,
    output logic              qry_ready,
    input  logic [DATA_W-1:0] qry_data,
    input  logic [TAG_W-1:0]  qry_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] rsp_data,
    output logic              bf_insert_valid,
    output logic [DATA_W-1:0] bf_insert_data,
    output logic              bf_query_valid,
    output logic [DATA_W-1:0] bf_query_data,
    input  logic              bf_query_result
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int IW = $clog2(INIT_CYC + 1);

    sched_state_e state_q, state_d;
    logic [IW-1:0] init_cnt_q;
    logic          run;

    logic              ins_push, ins_pop, ins_full, ins_empty;
    logic [DATA_W-1:0] ins_head;
    logic              qry_push, qry_pop, qry_full, qry_empty;
    qry_req_t          qry_wdata, qry_head;
    logic              rsp_push, rsp_pop, rsp_full, rsp_empty;
    rsp_t              rsp_wdata, rsp_head;

    logic [CW-1:0]     credits_q;
    logic              ins_strobe_q;
    logic [DATA_W-1:0] ins_strobe_data_q;

    // Stage 0 is the registered query strobe; stage QRY_LAT lines up with
    // the cycle in which bf_query_result belongs to that query.
    logic              pipe_v   [QRY_LAT+1];
    qry_req_t          pipe_req [QRY_LAT+1];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= IW'(INIT_CYC - 1);
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT && init_cnt_q != '0)
                init_cnt_q <= init_cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        case (state_q)
            ST_INIT: if (init_cnt_q == '0) state_d = ST_RUN;
            ST_RUN:  run = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    // ---------------- request side ----------------
    assign ins_ready = !rst && run && !ins_full;
    assign qry_ready = !rst && run && !qry_full;
    assign ins_push  = ins_valid && ins_ready;
    assign qry_push  = qry_valid && qry_ready;

    always_comb begin
        qry_wdata      = '0;
        qry_wdata.tag  = qry_tag;
        qry_wdata.data = qry_data;
    end

    bloom_sync_fifo #(.T(logic [DATA_W-1:0]), .DEPTH(QDEPTH)) u_ins_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ins_push),
        .wr_data (ins_data),
        .rd_en   (ins_pop),
        .rd_data (ins_head),
        .full    (ins_full),
        .empty   (ins_empty)
    );

    bloom_sync_fifo #(.T(qry_req_t), .DEPTH(QDEPTH)) u_qry_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (qry_push),
        .wr_data (qry_wdata),
        .rd_en   (qry_pop),
        .rd_data (qry_head),
        .full    (qry_full),
        .empty   (qry_empty)
    );

    // ---------------- issue arbiter ----------------
    // A query may only issue while the insert FIFO is empty, so any insert
    // accepted no later than a query is strobed before it. The rsp_full term
    // is implied by the credit limit and only guards against misuse.
    assign ins_pop = run && !ins_empty;
    assign qry_pop = run && ins_empty && !qry_empty
                     && (credits_q < CW'(QDEPTH)) && !rsp_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            ins_strobe_q <= 1'b0;
            credits_q    <= '0;
            for (int i = 0; i <= QRY_LAT; i++) pipe_v[i] <= 1'b0;
        end else begin
            ins_strobe_q <= ins_pop;
            pipe_v[0]    <= qry_pop;
            for (int i = 1; i <= QRY_LAT; i++) pipe_v[i] <= pipe_v[i-1];
            case ({qry_pop, rsp_pop})
                2'b10:   credits_q <= credits_q + 1'b1;
                2'b01:   credits_q <= credits_q - 1'b1;
                default: credits_q <= credits_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ins_pop) ins_strobe_data_q <= ins_head;
        if (qry_pop) pipe_req[0] <= qry_head;
        for (int i = 1; i <= QRY_LAT; i++) pipe_req[i] <= pipe_req[i-1];
    end

    assign bf_insert_valid = !rst && ins_strobe_q;
    assign bf_insert_data  = rst ? '0 : ins_strobe_data_q;
    assign bf_query_valid  = !rst && pipe_v[0];
    assign bf_query_data   = rst ? '0 : pipe_req[0].data;

    // ---------------- response side ----------------
    assign rsp_push = pipe_v[QRY_LAT];

    always_comb begin
        rsp_wdata      = '0;
        rsp_wdata.tag  = pipe_req[QRY_LAT].tag;
        rsp_wdata.data = pipe_req[QRY_LAT].data;
        rsp_wdata.hit  = bf_query_result;
    end

    bloom_sync_fifo #(.T(rsp_t), .DEPTH(QDEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rsp_push),
        .wr_data (rsp_wdata),
        .rd_en   (rsp_pop),
        .rd_data (rsp_head),
        .full    (rsp_full),
        .empty   (rsp_empty)
    );

    assign rsp_valid = !rst && !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_hit   = rsp_valid && rsp_head.hit;
    assign rsp_tag   = rsp_valid ? rsp_head.tag  : '0;
    assign rsp_data  = rsp_valid ? rsp_head.data : '0;

endmodule

// File: tb/tb_bloom_req_sched.sv
// Directed bench for bloom_req_sched with an exact-set bloom_filter model
// (no false positives, result one cycle after the query strobe).
module tb_bloom_req_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [31:0] ins_data = '0;
    logic        qry_valid = 1'b0;
    logic        qry_ready;
    logic [31:0] qry_data = '0;
    logic [3:0]  qry_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_hit;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_data;
    logic        bf_insert_valid;
    logic [31:0] bf_insert_data;
    logic        bf_query_valid;
    logic [31:0] bf_query_data;
    logic        bf_query_result = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int ins_strobes = 0;
    int qry_strobes = 0;
    int last_ins_cyc = 0;
    int last_qry_cyc = 0;

    localparam logic [31:0] K1 = 32'hc0a9011e;
    localparam logic [31:0] K2 = 32'hc0a8011e;
    localparam logic [31:0] K3 = 32'hc0a90128;
    localparam logic [31:0] K4 = 32'h1234abcd;

    bloom_req_sched #(.QDEPTH(4), .QRY_LAT(1), .INIT_CYC(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .ins_valid       (ins_valid),
        .ins_ready       (ins_ready),
        .ins_data        (ins_data),
        .qry_valid       (qry_valid),
        .qry_ready       (qry_ready),
        .qry_data        (qry_data),
        .qry_tag         (qry_tag),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_hit         (rsp_hit),
        .rsp_tag         (rsp_tag),
        .rsp_data        (rsp_data),
        .bf_insert_valid (bf_insert_valid),
        .bf_insert_data  (bf_insert_data),
        .bf_query_valid  (bf_query_valid),
        .bf_query_data   (bf_query_data),
        .bf_query_result (bf_query_result)
    );

    always #5 clk = ~clk;

    // Behavioural bloom_filter: exact key set, cleared by reset.
    bit kset [logic [31:0]];
    always @(posedge clk) begin
        if (rst) begin
            kset.delete();
            bf_query_result <= 1'b0;
        end else begin
            bf_query_result <= bf_query_valid ? kset.exists(bf_query_data) : 1'b0;
            if (bf_insert_valid) kset[bf_insert_data] = 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (bf_insert_valid) begin ins_strobes++; last_ins_cyc = cyc; end
        if (bf_query_valid)  begin qry_strobes++; last_qry_cyc = cyc; end
    end

    function automatic logic [31:0] bp_key(input int t);
        bp_key = (t % 2 == 0) ? K1 : (32'h5000_0000 + 32'(t));
    endfunction

    task automatic send_ins(input logic [31:0] k);
        int n = 0;
        ins_valid = 1'b1;
        ins_data  = k;
        while (!ins_ready && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 100) $display("FAIL ins_accept: ins_ready stayed %0b, required 1", ins_ready);
        else n_pass++;
        @(negedge clk);
        ins_valid = 1'b0;
    endtask

    task automatic send_qry(input logic [31:0] k, input logic [3:0] t);
        int n = 0;
        qry_valid = 1'b1;
        qry_data  = k;
        qry_tag   = t;
        while (!qry_ready && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 100) $display("FAIL qry_accept tag %0d: qry_ready stayed %0b, required 1", t, qry_ready);
        else n_pass++;
        @(negedge clk);
        qry_valid = 1'b0;
    endtask

    task automatic get_rsp(input logic [3:0] t, input logic [31:0] k, input logic h);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 100 || rsp_tag !== t || rsp_data !== k || rsp_hit !== h)
            $display("FAIL rsp tag %0d: got valid=%0b tag=%0d data=%h hit=%0b, required tag=%0d data=%h hit=%0b",
                     t, rsp_valid, rsp_tag, rsp_data, rsp_hit, t, k, h);
        else n_pass++;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({ins_ready, qry_ready, rsp_valid, bf_insert_valid, bf_query_valid} !== 5'b0
            || rsp_tag !== 4'd0 || rsp_data !== 32'd0 || bf_query_data !== 32'd0)
            $display("FAIL reset_outputs: got rdy=%0b%0b rsp_v=%0b bf_v=%0b%0b, required all 0",
                     ins_ready, qry_ready, rsp_valid, bf_insert_valid, bf_query_valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ins_ready !== 1'b0 || qry_ready !== 1'b0)
                $display("FAIL init_ready cycle %0d: got ins=%0b qry=%0b, required 0 0", i, ins_ready, qry_ready);
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (ins_ready !== 1'b1 || qry_ready !== 1'b1)
            $display("FAIL run_ready: got ins=%0b qry=%0b, required 1 1", ins_ready, qry_ready);
        else n_pass++;
        n_checks++;
        if (ins_strobes !== 0 || qry_strobes !== 0)
            $display("FAIL init_strobes: got ins=%0d qry=%0d, required 0 0", ins_strobes, qry_strobes);
        else n_pass++;
    endtask

    task automatic test_insert_query();
        int i0 = ins_strobes;
        int q0 = qry_strobes;
        send_ins(K1);
        send_qry(K1, 4'd3);
        get_rsp(4'd3, K1, 1'b1);
        #1;
        n_checks++;
        if (ins_strobes - i0 !== 1 || qry_strobes - q0 !== 1)
            $display("FAIL ins_qry_strobes: got ins=%0d qry=%0d, required 1 1", ins_strobes - i0, qry_strobes - q0);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        n_checks++;
        if (ins_ready !== 1'b1 || qry_ready !== 1'b1)
            $display("FAIL same_cycle_ready: got ins=%0b qry=%0b, required 1 1", ins_ready, qry_ready);
        else n_pass++;
        ins_valid = 1'b1; ins_data = K2;
        qry_valid = 1'b1; qry_data = K2; qry_tag = 4'd5;
        @(negedge clk);
        ins_valid = 1'b0;
        qry_valid = 1'b0;
        get_rsp(4'd5, K2, 1'b1);
        #1;
        n_checks++;
        if (last_qry_cyc !== last_ins_cyc + 1)
            $display("FAIL insert_priority: got query strobe at cycle %0d, required %0d", last_qry_cyc, last_ins_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_miss();
        send_qry(K3, 4'd7);
        get_rsp(4'd7, K3, 1'b0);
    endtask

    task automatic test_back_pressure();
        int q0 = qry_strobes;
        rsp_ready = 1'b0;
        for (int t = 0; t < 6; t++) send_qry(bp_key(t), 4'(t));
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (qry_strobes - q0 !== 4)
            $display("FAIL credit_limit: got %0d query strobes, required 4", qry_strobes - q0);
        else n_pass++;
        n_checks++;
        if (qry_ready !== 1'b1)
            $display("FAIL qry_ready_two_buffered: got %0b, required 1", qry_ready);
        else n_pass++;
        send_qry(bp_key(6), 4'd6);
        send_qry(bp_key(7), 4'd7);
        #1;
        n_checks++;
        if (qry_ready !== 1'b0)
            $display("FAIL qry_ready_full: got %0b, required 0", qry_ready);
        else n_pass++;
        for (int t = 0; t < 8; t++) get_rsp(4'(t), bp_key(t), (t % 2 == 0));
        #1;
        n_checks++;
        if (qry_strobes - q0 !== 8)
            $display("FAIL bp_total_strobes: got %0d, required 8", qry_strobes - q0);
        else n_pass++;
    endtask

    task automatic test_reset_in_flight();
        int seen = 0;
        int q0 = qry_strobes;
        rsp_ready = 1'b0;
        send_qry(32'h7000_0009, 4'd9);
        send_qry(32'h7000_000a, 4'd10);
        @(negedge clk);
        #1;
        n_checks++;
        if (qry_strobes - q0 !== 2)
            $display("FAIL inflight_issue: got %0d strobes, required 2", qry_strobes - q0);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0)
            $display("FAIL rsp_valid_in_rst: got %0b, required 0", rsp_valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0)
            $display("FAIL rsp_valid_after_rst: got %0b, required 0", rsp_valid);
        else n_pass++;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (seen !== 0)
            $display("FAIL stale_rsp: got %0d responses after rst, required 0", seen);
        else n_pass++;
        n_checks++;
        if (ins_ready !== 1'b1 || qry_ready !== 1'b1)
            $display("FAIL resume_ready: got ins=%0b qry=%0b, required 1 1", ins_ready, qry_ready);
        else n_pass++;
        send_ins(K4);
        send_qry(K4, 4'd12);
        get_rsp(4'd12, K4, 1'b1);
    endtask

    initial begin
        test_reset();
        test_insert_query();
        test_same_cycle();
        test_miss();
        test_back_pressure();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
